nibble_serial_add16: RTL
========================

# nibble_serial_add16

Multi-cycle 16-bit add/subtract unit that sequences a full-width operation through a single 4-bit nibble adder datapath, one nibble per clock, least-significant nibble first. Sits directly around the 4-bit ripple adder stage: latches operands, feeds each nibble plus the registered inter-nibble carry into the nibble adder, and collects its sum and carry outputs into a 16-bit result with flags. Used where one narrow adder is shared for wide arithmetic at the cost of latency.

## Interface
- No parameters; width fixed at 16 bits (4 nibbles).
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a new operation; sampled on rising edge
- sub  input  1  0 = a + b, 1 = a - b; latched with operands
- a  input  16  operand A; latched when start is accepted
- b  input  16  operand B; latched when start is accepted
- busy  output  1  high while an operation is in progress (state ADD)
- done  output  1  one-cycle pulse: result outputs just updated
- sum  output  16  result register
- cout  output  1  carry out of bit 15 (sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow
- zero  output  1  sum == 16'h0000
- neg  output  1  sum[15]

## Operation
- States: IDLE, ADD, DONE. 2-bit nibble index idx, 1-bit carry register c, 16-bit operand registers ra/rb, 16-bit partial register p.
- Accept: start high in IDLE or DONE -> ra = a, rb = sub ? ~b : b, c = sub, idx = 0, p cleared, state = ADD.
- ADD, each cycle: {c', s} = ra[4*idx+3:4*idx] + rb[4*idx+3:4*idx] + c (5-bit result); p nibble idx = s; c = c'; idx increments.
- At idx == 3: write final nibble, load sum = {s, p[11:0]}, cout = c', ovf = (ra[15] == rb[15]) && (s[3] != ra[15]), zero, neg from final sum; state = DONE.
- DONE: done = 1 for exactly this cycle; state -> IDLE next edge unless start accepted (back-to-back).
- start in ADD: ignored, operands not relatched, operation unaffected.
- sum, cout, ovf, zero, neg hold their value from the last completed operation until the next completion; never show partial results.
- Arithmetic modulo 2^16; sub implemented as a + ~b + 1 via carry-in = 1.

## Timing
- Reset (rst_n low, any time, asynchronous): state = IDLE, busy = 0, done = 0, sum = 16'h0000, cout = 0, ovf = 0, zero = 0, neg = 0, idx = 0, c = 0. An in-flight operation is abandoned; no done pulse is issued for it.
- Edge E0: start accepted. busy = 1 from after E0.
- Edges E1..E4: nibbles 0..3 computed. After E4: results valid, done = 1, busy = 0.
- After E5: done = 0 (IDLE), or busy = 1 again if start was high at E5.
- Latency: 4 cycles start-to-done; throughput: one operation per 5 cycles.
- a, b, sub must only be stable at the accepting edge; later changes have no effect.
- Flags computed combinationally from final nibble but registered; all outputs are register outputs.

## Test plan
- Reset: assert rst_n low two cycles into an ADD of 0x1111 + 0x2222 -> all outputs 0 immediately, no done pulse; after release, IDLE with busy = 0.
- Carry chain: 0x00FF + 0x0001, sub = 0 -> done exactly 4 cycles after accept, sum = 0x0100, cout = 0, ovf = 0, zero = 0, neg = 0.
- Wrap: 0xFFFF + 0x0001 -> sum = 0x0000, cout = 1, zero = 1, ovf = 0, neg = 0.
- Signed overflow: 0x7FFF + 0x0001 -> sum = 0x8000, ovf = 1, neg = 1, cout = 0; subtract 0x8000 - 0x0001 -> sum = 0x7FFF, ovf = 1, cout = 1.
- Subtract: 0x1234 - 0x1234 -> sum = 0x0000, zero = 1, cout = 1; 0x0001 - 0x0002 -> sum = 0xFFFF, cout = 0, neg = 1.
- Handshake: start held high with changing operands during ADD -> ignored, result matches first operands; start in DONE cycle with 0x0003 + 0x0004 -> accepted, second done 5 cycles after first, sum = 0x0007.

Source files
------------

// File: rtl/nibble_serial_add16_if.sv
// Operand/result bundle for the nibble-serial 16-bit adder.
// The master drives operands and start; the slave returns status and results.
interface nibble_serial_add16_if;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/nibble_serial_add16.sv
// 16-bit add/subtract sequenced through one 4-bit adder, LS nibble first.
// Four cycles from accept to done; result and flags only change on completion.
module nibble_serial_add16 (
    input logic                  clk,
    input logic                  rst_n,
    nibble_serial_add16_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        c_q, c_d;
    logic [15:0] ra_q, ra_d;
    logic [15:0] rb_q, rb_d;
    logic [15:0] p_q, p_d;
    logic [15:0] sum_q, sum_d;
    logic        cout_q, cout_d;
    logic        ovf_q, ovf_d;
    logic        zero_q, zero_d;
    logic        neg_q, neg_d;

    logic [3:0]  nib_a, nib_b;
    logic [4:0]  nib_res;
    logic [15:0] final_sum;

    // The shared nibble adder: current operand nibbles plus registered carry.
    assign nib_a     = ra_q[{idx_q, 2'b00} +: 4];
    assign nib_b     = rb_q[{idx_q, 2'b00} +: 4];
    assign nib_res   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, c_q};
    assign final_sum = {nib_res[3:0], p_q[11:0]};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        p_d     = p_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1, with the +1 entering as carry-in.
                    ra_d    = bus.a;
                    rb_d    = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.sub;
                    idx_d   = 2'd0;
                    p_d     = 16'h0000;
                    state_d = StAdd;
                end else begin
                    state_d = StIdle;
                end
            end
            StAdd: begin
                p_d[{idx_q, 2'b00} +: 4] = nib_res[3:0];
                c_d   = nib_res[4];
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    sum_d   = final_sum;
                    cout_d  = nib_res[4];
                    ovf_d   = (ra_q[15] == rb_q[15]) && (nib_res[3] != ra_q[15]);
                    zero_d  = (final_sum == 16'h0000);
                    neg_d   = nib_res[3];
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            c_q     <= 1'b0;
            ra_q    <= 16'h0000;
            rb_q    <= 16'h0000;
            p_q     <= 16'h0000;
            sum_q   <= 16'h0000;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            p_q     <= p_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.busy = (state_q == StAdd);
    assign bus.done = (state_q == StDone);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;

endmodule
